// File: rtl/uart_debug_bridge.sv
// uart_debug_bridge: host-command responder behind uart_controller.
// Decodes ping (0x50), 32-bit write (0x57) and 32-bit read (0x52) commands
// arriving as bytes, runs single-beat bus transactions and returns reply
// bytes through the transmit handshake.
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   rev_data[7:0]      : received byte, pending while rev_data_valid is high
//   rev_data_valid     : a received byte is waiting
//   rev_data_invalid   : combinational consume strobe, one cycle per byte
//   send_data[7:0]     : byte to transmit, stable while send is high
//   send               : one-cycle transmit request
//   send_busy          : transmitter busy
//   bus_req/bus_we     : bus request, write enable (held until bus_ack)
//   bus_addr/bus_wdata : transaction address and write data
//   bus_ack/bus_rdata  : completion strobe and read data
module uart_debug_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rev_data,
  input  logic        rev_data_valid,
  output logic        rev_data_invalid,
  output logic [7:0]  send_data,
  output logic        send,
  input  logic        send_busy,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RX_ADDR = 3'd1;
  localparam logic [2:0] S_RX_DATA = 3'd2;
  localparam logic [2:0] S_BUS     = 3'd3;
  localparam logic [2:0] S_TX      = 3'd4;
  localparam logic [2:0] S_TX_WAIT = 3'd5;

  localparam logic [7:0] OP_PING  = 8'h50;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_ERR  = 8'h45;

  logic [2:0]       state_q, state_d;
  logic [2:0]       byte_cnt_q, byte_cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [31:0]      rbuf_q, rbuf_d;      // reply bytes not yet sent, LSB next
  logic [2:0]       tx_left_q, tx_left_d;
  logic             seen_busy_q, seen_busy_d;

  logic        send_d;
  logic [7:0]  send_data_d;
  logic        bus_req_d;
  logic        bus_we_d;
  logic [31:0] bus_addr_d;
  logic [31:0] bus_wdata_d;

  logic        consume;
  logic        tmo_hit;
  logic        launch;
  logic [31:0] l_val;
  logic [2:0]  l_cnt;

  // Bytes are only taken in the receive states; others stay pending.
  assign consume = rev_data_valid && !rst &&
                   ((state_q == S_IDLE) || (state_q == S_RX_ADDR) ||
                    (state_q == S_RX_DATA));
  assign rev_data_invalid = consume;

  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Next-state and datapath decode.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    tmo_d       = tmo_q;
    rbuf_d      = rbuf_q;
    tx_left_d   = tx_left_q;
    seen_busy_d = seen_busy_q;
    send_d      = 1'b0;
    send_data_d = send_data;
    bus_req_d   = bus_req;
    bus_we_d    = bus_we;
    bus_addr_d  = bus_addr;
    bus_wdata_d = bus_wdata;
    launch      = 1'b0;
    l_val       = rbuf_q;
    l_cnt       = tx_left_q;

    case (state_q)
      S_IDLE: begin
        if (consume) begin
          tmo_d      = '0;
          byte_cnt_d = '0;
          case (rev_data)
            OP_WRITE: begin
              bus_we_d = 1'b1;
              state_d  = S_RX_ADDR;
            end
            OP_READ: begin
              bus_we_d = 1'b0;
              state_d  = S_RX_ADDR;
            end
            OP_PING: begin
              launch = 1'b1;
              l_val  = 32'(RSP_OK);
              l_cnt  = 3'd1;
            end
            default: begin
              launch = 1'b1;
              l_val  = 32'(RSP_ERR);
              l_cnt  = 3'd1;
            end
          endcase
        end
      end

      S_RX_ADDR, S_RX_DATA: begin
        if (consume) begin
          tmo_d = '0;
          // Little-endian: each byte enters at the top and shifts down.
          if (state_q == S_RX_ADDR) bus_addr_d = {rev_data, bus_addr[31:8]};
          else                      bus_wdata_d = {rev_data, bus_wdata[31:8]};
          if (byte_cnt_q == 3'd3) begin
            byte_cnt_d = '0;
            if ((state_q == S_RX_ADDR) && bus_we) begin
              state_d = S_RX_DATA;
            end else begin
              state_d   = S_BUS;
              bus_req_d = 1'b1;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end else if (tmo_hit) begin
          // Stalled host: drop the partial command silently.
          state_d     = S_IDLE;
          tmo_d       = '0;
          byte_cnt_d  = '0;
          bus_addr_d  = '0;
          bus_wdata_d = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_BUS: begin
        if (bus_ack) begin
          bus_req_d = 1'b0;
          launch    = 1'b1;
          if (bus_we) begin
            l_val = 32'(RSP_OK);
            l_cnt = 3'd1;
          end else begin
            l_val = bus_rdata;
            l_cnt = 3'd4;
          end
        end
      end

      S_TX: begin
        launch = 1'b1;
      end

      S_TX_WAIT: begin
        // A byte is done only after busy has been seen rising and falling.
        if (send_busy) begin
          seen_busy_d = 1'b1;
        end else if (seen_busy_q) begin
          if (tx_left_q != 3'd0) launch  = 1'b1;
          else                   state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Shared transmit launch: send now if the transmitter is free,
    // otherwise park the reply in TX until it is.
    if (launch) begin
      if (!send_busy) begin
        send_d      = 1'b1;
        send_data_d = l_val[7:0];
        rbuf_d      = l_val >> 8;
        tx_left_d   = l_cnt - 3'd1;
        seen_busy_d = 1'b0;
        state_d     = S_TX_WAIT;
      end else begin
        rbuf_d    = l_val;
        tx_left_d = l_cnt;
        state_d   = S_TX;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= '0;
      tmo_q       <= '0;
      rbuf_q      <= '0;
      tx_left_q   <= '0;
      seen_busy_q <= 1'b0;
      send        <= 1'b0;
      send_data   <= '0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      tmo_q       <= tmo_d;
      rbuf_q      <= rbuf_d;
      tx_left_q   <= tx_left_d;
      seen_busy_q <= seen_busy_d;
      send        <= send_d;
      send_data   <= send_data_d;
      bus_req     <= bus_req_d;
      bus_we      <= bus_we_d;
      bus_addr    <= bus_addr_d;
      bus_wdata   <= bus_wdata_d;
    end
  end

endmodule

// File: tb/tb_uart_debug_bridge.sv
// tb_uart_debug_bridge: self-checking bench for uart_debug_bridge with UART
// receive/transmit models, a bus responder and reply/bus scoreboards.
module tb_uart_debug_bridge;

  localparam int unsigned TMO = 100;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rev_data;
  logic        rev_data_valid;
  logic        rev_data_invalid;
  logic [7:0]  send_data;
  logic        send;
  logic        send_busy;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  bus_exp_t   bus_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int ncyc = 0, last_cons = 0, ack_cyc = 0;
  int n_cons = 0, n_sends = 0, n_bus = 0, n_req_rises = 0;
  bit ack_pending = 0, prev_req = 0, prev_send = 0;
  bit rx_take = 0, tx_fire = 0, rx_flush = 0;
  logic [31:0] hold_addr, hold_wdata;
  logic        hold_we;
  int          ack_delay = 0;
  bit          withhold = 0, spurious = 0;
  logic [31:0] rd_val = '0;
  int          busy_len = 6;

  uart_debug_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk              (clk),
    .rst              (rst),
    .rev_data         (rev_data),
    .rev_data_valid   (rev_data_valid),
    .rev_data_invalid (rev_data_invalid),
    .send_data        (send_data),
    .send             (send),
    .send_busy        (send_busy),
    .bus_req          (bus_req),
    .bus_we           (bus_we),
    .bus_addr         (bus_addr),
    .bus_wdata        (bus_wdata),
    .bus_ack          (bus_ack),
    .bus_rdata        (bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Receive side of uart_controller: valid held until consumed.
  initial begin
    bit t;
    rev_data = '0;
    rev_data_valid = 1'b0;
    forever begin
      @(posedge clk);
      t = rx_take;
      #1;
      if (t || rx_flush) rev_data_valid = 1'b0;
      if (!rx_flush && !rev_data_valid && rx_q.size() > 0) begin
        rev_data = rx_q.pop_front();
        rev_data_valid = 1'b1;
      end
    end
  end

  // Transmitter: busy rises the cycle after send for busy_len cycles.
  initial begin
    bit t;
    int busy_cnt;
    busy_cnt = 0;
    send_busy = 1'b0;
    forever begin
      @(posedge clk);
      t = tx_fire;
      #1;
      if (t) busy_cnt = busy_len;
      if (busy_cnt > 0) begin
        send_busy = 1'b1;
        busy_cnt--;
      end else begin
        send_busy = 1'b0;
      end
    end
  end

  // Bus responder with programmable ack delay; random rdata outside ack.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus_ack = 1'b0;
    bus_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus_rdata = $urandom;
      if (bus_req && !withhold) begin
        if (wait_cnt >= ack_delay) begin
          bus_ack = 1'b1;
          bus_rdata = rd_val;
        end else begin
          bus_ack = 1'b0;
          wait_cnt++;
        end
      end else if (bus_req) begin
        bus_ack = 1'b0;
      end else begin
        bus_ack = spurious;
        wait_cnt = 0;
      end
    end
  end

  // Monitor and scoreboard, sampled mid-cycle.
  initial begin
    bus_exp_t e;
    logic [7:0] eb;
    forever begin
      @(negedge clk);
      rx_take = rev_data_valid && rev_data_invalid;
      tx_fire = send;
      if (!rst) begin
        ncyc++;
        if (rev_data_invalid) begin
          n_cons++;
          last_cons = ncyc;
        end
        if (bus_req) begin
          if (!prev_req) begin
            n_req_rises++;
            n_checks++;
            if (ncyc != last_cons + 1) begin
              n_fail++;
              $display("FAIL bus_req_latency: req at cycle %0d, required %0d", ncyc, last_cons + 1);
            end
            hold_addr = bus_addr; hold_wdata = bus_wdata; hold_we = bus_we;
            n_checks++;
            if (bus_q.size() == 0) begin
              n_fail++;
              $display("FAIL bus_unexpected: got req addr %h we %b, required none", bus_addr, bus_we);
            end else begin
              e = bus_q.pop_front();
              if (bus_we !== e.we || bus_addr !== e.addr || (e.we && bus_wdata !== e.wdata)) begin
                n_fail++;
                $display("FAIL bus_fields: got we %b addr %h wdata %h, required we %b addr %h wdata %h",
                         bus_we, bus_addr, bus_wdata, e.we, e.addr, e.wdata);
              end
            end
          end else begin
            n_checks++;
            if (bus_addr !== hold_addr || bus_we !== hold_we || bus_wdata !== hold_wdata) begin
              n_fail++;
              $display("FAIL bus_stable: got addr %h we %b wdata %h, required addr %h we %b wdata %h",
                       bus_addr, bus_we, bus_wdata, hold_addr, hold_we, hold_wdata);
            end
          end
          if (bus_ack) begin
            n_bus++;
            ack_cyc = ncyc;
            ack_pending = 1'b1;
          end
        end
        if (send) begin
          n_sends++;
          n_checks++;
          if (send_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL send_while_busy: got send_busy %b, required 0", send_busy);
          end
          n_checks++;
          if (prev_send) begin
            n_fail++;
            $display("FAIL send_consecutive: got send high on two cycles, required single pulse");
          end
          if (ack_pending) begin
            n_checks++;
            if (ncyc != ack_cyc + 1) begin
              n_fail++;
              $display("FAIL send_after_ack: got send at cycle %0d, required %0d", ncyc, ack_cyc + 1);
            end
            ack_pending = 1'b0;
          end
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL send_unexpected: got byte %h, required none", send_data);
          end else begin
            eb = exp_q.pop_front();
            if (send_data !== eb) begin
              n_fail++;
              $display("FAIL send_data: got %h, required %h", send_data, eb);
            end
          end
        end
      end
      prev_req = bus_req;
      prev_send = send;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    rx_q.delete();
    rx_flush = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rx_flush = 1'b0;
    exp_q.delete();
    bus_q.delete();
    ack_pending = 1'b0;
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && bus_q.size() == 0 && rx_q.size() == 0 &&
          !rev_data_valid && !send_busy && !bus_req && !send)
        done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d replies / %0d bus ops outstanding, required 0",
               name, exp_q.size(), bus_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++; if (send !== 1'b0)      begin n_fail++; $display("FAIL reset_send: got %b, required 0", send); end
    n_checks++; if (send_data !== 8'h0) begin n_fail++; $display("FAIL reset_send_data: got %h, required 00", send_data); end
    n_checks++; if (rev_data_invalid !== 1'b0) begin n_fail++; $display("FAIL reset_invalid: got %b, required 0", rev_data_invalid); end
    n_checks++; if (bus_req !== 1'b0)   begin n_fail++; $display("FAIL reset_bus_req: got %b, required 0", bus_req); end
    n_checks++; if (bus_we !== 1'b0)    begin n_fail++; $display("FAIL reset_bus_we: got %b, required 0", bus_we); end
    n_checks++; if (bus_addr !== 32'h0) begin n_fail++; $display("FAIL reset_bus_addr: got %h, required 0", bus_addr); end
    n_checks++; if (bus_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_bus_wdata: got %h, required 0", bus_wdata); end
  endtask

  task automatic test_ping();
    int c0, s0, r0;
    c0 = n_cons; s0 = n_sends; r0 = n_req_rises;
    spurious = 1'b1;
    exp_q.push_back(8'h4B);
    rx_q.push_back(8'h50);
    wait_idle("ping", 200);
    spurious = 1'b0;
    n_checks++; if (n_cons - c0 != 1) begin n_fail++; $display("FAIL ping_consumes: got %0d, required 1", n_cons - c0); end
    n_checks++; if (n_sends - s0 != 1) begin n_fail++; $display("FAIL ping_sends: got %0d, required 1", n_sends - s0); end
    n_checks++; if (n_req_rises != r0) begin n_fail++; $display("FAIL ping_bus: got %0d requests, required 0", n_req_rises - r0); end
  endtask

  task automatic test_write();
    logic [7:0] cmd [9] = '{8'h57, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    int c0, s0, b0;
    c0 = n_cons; s0 = n_sends; b0 = n_bus;
    ack_delay = 3;
    bus_q.push_back('{we: 1'b1, addr: 32'h1234_5678, wdata: 32'hDEAD_BEEF});
    exp_q.push_back(8'h4B);
    foreach (cmd[i]) rx_q.push_back(cmd[i]);
    wait_idle("write", 300);
    n_checks++; if (n_cons - c0 != 9) begin n_fail++; $display("FAIL write_consumes: got %0d, required 9", n_cons - c0); end
    n_checks++; if (n_bus - b0 != 1) begin n_fail++; $display("FAIL write_bus_ops: got %0d, required 1", n_bus - b0); end
    n_checks++; if (n_sends - s0 != 1) begin n_fail++; $display("FAIL write_sends: got %0d, required 1", n_sends - s0); end
  endtask

  task automatic test_read();
    logic [7:0] cmd [5] = '{8'h52, 8'h00, 8'h10, 8'h00, 8'h80};
    int s0, b0;
    s0 = n_sends; b0 = n_bus;
    ack_delay = 0;
    rd_val = 32'hA1B2_C3D4;
    bus_q.push_back('{we: 1'b0, addr: 32'h8000_1000, wdata: 32'h0});
    exp_q.push_back(8'hD4); exp_q.push_back(8'hC3);
    exp_q.push_back(8'hB2); exp_q.push_back(8'hA1);
    foreach (cmd[i]) rx_q.push_back(cmd[i]);
    wait_idle("read", 300);
    n_checks++; if (n_bus - b0 != 1) begin n_fail++; $display("FAIL read_bus_ops: got %0d, required 1", n_bus - b0); end
    n_checks++; if (n_sends - s0 != 4) begin n_fail++; $display("FAIL read_sends: got %0d, required 4", n_sends - s0); end
  endtask

  task automatic test_unknown();
    int c0, s0, r0;
    c0 = n_cons; s0 = n_sends; r0 = n_req_rises;
    exp_q.push_back(8'h45);
    exp_q.push_back(8'h4B);
    rx_q.push_back(8'hFF);
    rx_q.push_back(8'h50);
    wait_idle("unknown", 300);
    n_checks++; if (n_cons - c0 != 2) begin n_fail++; $display("FAIL unknown_consumes: got %0d, required 2", n_cons - c0); end
    n_checks++; if (n_sends - s0 != 2) begin n_fail++; $display("FAIL unknown_sends: got %0d, required 2", n_sends - s0); end
    n_checks++; if (n_req_rises != r0) begin n_fail++; $display("FAIL unknown_bus: got %0d requests, required 0", n_req_rises - r0); end
  endtask

  task automatic test_timeout();
    int c0, s0, r0;
    c0 = n_cons; s0 = n_sends; r0 = n_req_rises;
    rx_q.push_back(8'h57); rx_q.push_back(8'h01); rx_q.push_back(8'h02);
    repeat (TMO + 10) @(posedge clk);
    #2;
    n_checks++; if (n_cons - c0 != 3) begin n_fail++; $display("FAIL timeout_consumes: got %0d, required 3", n_cons - c0); end
    n_checks++; if (n_sends != s0) begin n_fail++; $display("FAIL timeout_sends: got %0d, required 0", n_sends - s0); end
    n_checks++; if (n_req_rises != r0) begin n_fail++; $display("FAIL timeout_bus: got %0d requests, required 0", n_req_rises - r0); end
    exp_q.push_back(8'h4B);
    rx_q.push_back(8'h50);
    wait_idle("timeout_ping", 200);
    n_checks++; if (n_sends - s0 != 1) begin n_fail++; $display("FAIL timeout_ping_sends: got %0d, required 1", n_sends - s0); end
  endtask

  // Gaps just under the limit must not abort the command.
  task automatic test_slow_host();
    int b0;
    b0 = n_bus;
    ack_delay = 1;
    rd_val = 32'h0BAD_F00D;
    bus_q.push_back('{we: 1'b0, addr: 32'h0000_2000, wdata: 32'h0});
    exp_q.push_back(8'h0D); exp_q.push_back(8'hF0);
    exp_q.push_back(8'hAD); exp_q.push_back(8'h0B);
    rx_q.push_back(8'h52);
    repeat (TMO - 8) @(posedge clk);
    rx_q.push_back(8'h00); rx_q.push_back(8'h20);
    repeat (TMO - 8) @(posedge clk);
    rx_q.push_back(8'h00); rx_q.push_back(8'h00);
    wait_idle("slow_host", 300);
    n_checks++; if (n_bus - b0 != 1) begin n_fail++; $display("FAIL slow_host_bus_ops: got %0d, required 1", n_bus - b0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] cmd [14] = '{8'h57, 8'h40, 8'h00, 8'h00, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01,
                             8'h52, 8'h40, 8'h00, 8'h00, 8'h00};
    int c0, b0;
    c0 = n_cons; b0 = n_bus;
    ack_delay = 1;
    rd_val = 32'h0102_0304;
    bus_q.push_back('{we: 1'b1, addr: 32'h0000_0040, wdata: 32'h0102_0304});
    bus_q.push_back('{we: 1'b0, addr: 32'h0000_0040, wdata: 32'h0});
    exp_q.push_back(8'h4B);
    exp_q.push_back(8'h04); exp_q.push_back(8'h03);
    exp_q.push_back(8'h02); exp_q.push_back(8'h01);
    foreach (cmd[i]) rx_q.push_back(cmd[i]);
    wait_idle("back_to_back", 400);
    n_checks++; if (n_cons - c0 != 14) begin n_fail++; $display("FAIL b2b_consumes: got %0d, required 14", n_cons - c0); end
    n_checks++; if (n_bus - b0 != 2) begin n_fail++; $display("FAIL b2b_bus_ops: got %0d, required 2", n_bus - b0); end
  endtask

  task automatic test_reset_bus();
    logic [7:0] cmd [9] = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    bit seen;
    withhold = 1'b1;
    bus_q.push_back('{we: 1'b1, addr: 32'h0000_0010, wdata: 32'h4433_2211});
    foreach (cmd[i]) rx_q.push_back(cmd[i]);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus_req) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL rst_bus_req_seen: got no bus_req, required request"); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL rst_bus_req: got %b, required 0", bus_req); end
    n_checks++; if (send !== 1'b0) begin n_fail++; $display("FAIL rst_bus_send: got %b, required 0", send); end
    withhold = 1'b0;
    do_reset();
    exp_q.push_back(8'h4B);
    rx_q.push_back(8'h50);
    wait_idle("rst_bus_ping", 200);
  endtask

  task automatic test_reset_tx();
    logic [7:0] cmd [5] = '{8'h52, 8'h08, 8'h00, 8'h00, 8'h00};
    int s0;
    bit seen;
    s0 = n_sends;
    ack_delay = 0;
    rd_val = 32'h55AA_1234;
    bus_q.push_back('{we: 1'b0, addr: 32'h0000_0008, wdata: 32'h0});
    exp_q.push_back(8'h34); exp_q.push_back(8'h12);
    exp_q.push_back(8'hAA); exp_q.push_back(8'h55);
    foreach (cmd[i]) rx_q.push_back(cmd[i]);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (n_sends - s0 >= 1) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL rst_tx_first_send: got %0d sends, required 1", n_sends - s0); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (send !== 1'b0) begin n_fail++; $display("FAIL rst_tx_send: got %b, required 0", send); end
    n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL rst_tx_bus_req: got %b, required 0", bus_req); end
    do_reset();
    exp_q.push_back(8'h4B);
    rx_q.push_back(8'h50);
    wait_idle("rst_tx_ping", 200);
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_ping();
    test_write();
    test_read();
    test_unknown();
    test_timeout();
    test_slow_host();
    test_back_to_back();
    test_reset_bus();
    test_reset_tx();
    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
